pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register replacing the fixed, free-running stage latches in the CPU pipeline. Carries a WIDTH-bit data payload and a CTRL_W-bit control field (RegWr, MemWr, MemtoReg, ...) with valid/ready handshaking, flush, and an optional skid buffer. A bubble always presents all-zero control, so a stalled or flushed slot is a NOP downstream. Provides a saturating stall counter for performance monitoring.

Parameters:
WIDTH, 32, payload width (ALU result, busB, rd, MemOp packed by the instantiating stage)
CTRL_W, 3, control-field width; zeroed whenever the slot is invalid
SKID, 0, 0 = single entry with combinational in_ready; 1 = two-entry skid with registered in_ready
CNT_W, 16, stall-counter width

Ports:
clock  in  1  stage clock; all state updates on the falling edge
reset  in  1  asynchronous, active-high; clears all state immediately
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage accepts an entry on this edge
in_data  in  WIDTH  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  stage holds a valid entry
out_ready  in  1  downstream consumes the entry on this edge
out_data  out  WIDTH  head payload
out_ctrl  out  CTRL_W  head control; 0 when out_valid=0
flush  in  1  kill all held entries and any entry offered on this edge
stall_cnt  out  CNT_W  edges with out_valid=1 and out_ready=0, saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (asserted at any time, including mid-transfer): out_valid=0, out_data=0, out_ctrl=0, skid emptied, stall_cnt=0. Outputs update without waiting for a clock edge.
- Transfer in: occurs on a falling edge when in_valid & in_ready. Transfer out: occurs when out_valid & out_ready.
- Latency: 1 edge from accept to out_valid=1 when the stage is empty.
- out_ctrl = out_valid ? head_ctrl : 0. out_data holds its last value while invalid.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational path from out_ready).
  - Head loads on every accept.
  - If out_valid & ~out_ready, the head holds.
- SKID=1 states:
  - EMPTY (out_valid=0): in_ready=1. Accept -> FULL.
  - FULL (head only): in_ready=1. Accept & consume -> FULL, new head. Accept & ~consume -> BOTH, entry written to skid. Consume & ~accept -> EMPTY.
  - BOTH: in_ready=0. Consume -> FULL, skid moves to head.
- In SKID=1, in_ready is a registered output: in_ready = ~BOTH. Order is strict FIFO; no entry is dropped or duplicated.
- Flush:
  - Has priority over accept and consume on the same edge.
  - Next state is EMPTY, out_valid=0, out_ctrl=0.
  - An offered entry is not taken, although in_ready may read 1. Upstream treats a flush edge as a kill.
- stall_cnt:
  - Increments on each edge with out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr forces 0; if both clear and increment apply on the same edge, clear wins.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - the stage payload widths (ALUout 32, busB 32, MemOp 3, rd 5);
  - the control-field bit indices (CTRL_MEMTOREG=0, CTRL_REGWR=1, CTRL_MEMWR=2);
  - the skid state encodings.
- One sub-module, pipe_sat_counter, implements the saturating stall counter. The handshake and storage stay in pipe_stage_reg.

Test Plan:
1. Reset, then in_valid=1, in_data=0x0000_00A5, in_ctrl=3'b011, out_ready=1 -> after 1 falling edge: out_valid=1, out_data=0xA5, out_ctrl=3'b011.
2. SKID=1: fill the head with 0x11, hold out_ready=0, offer 0x22 -> 0x22 goes to the skid and in_ready=0. Offer 0x33, which is not taken. Raise out_ready -> output sequence 0x11, 0x22, then 0x33 after re-offer; no loss or duplicate.
3. SKID=0: out_valid=1 with out_ready=0 for 5 edges -> head unchanged, in_ready=0, stall_cnt=5. Pulse stall_clr -> stall_cnt=0.
4. Flush on an edge with in_valid=1 and out_ready=1, stage FULL -> out_valid=0, out_ctrl=0, offered entry discarded, stall_cnt unchanged.
5. CNT_W=4, hold the stall condition 20 edges -> stall_cnt=15 and stays 15.
6. Assert reset between edges while in SKID state BOTH -> out_valid, out_ctrl and stall_cnt go to 0 immediately. After release, in_ready=1 and the first accept appears after 1 edge.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stage payload widths, control-bit positions and skid-buffer state codes.
package cpu_pipe_pkg;

  localparam int ALUOUT_W = 32;
  localparam int BUSB_W   = 32;
  localparam int MEMOP_W  = 3;
  localparam int RD_W     = 5;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWR    = 1;
  localparam int CTRL_MEMWR    = 2;
  localparam int CTRL_W_DEF    = 3;

  // Bit 1 set only in BOTH, so ~state[1] is a flop-driven in_ready.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'b00,
    SK_FULL  = 2'b01,
    SK_BOTH  = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic [MEMOP_W-1:0]  mem_op;
    logic [RD_W-1:0]     rd;
    logic [BUSB_W-1:0]   bus_b;
    logic [ALUOUT_W-1:0] alu_out;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter on the falling clock edge; clear beats increment, no wrap at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, 1 falling edge accept-to-valid, flush kills held and offered entries.
// Backpressure: SKID=0 forwards out_ready to in_ready combinationally; SKID=1 uses a registered in_ready and a second slot.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  skid_state_e       state_q, state_d;
  logic [WIDTH-1:0]  head_data, skid_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic              accept, consume, stall_inc;
  logic              load_head, load_skid, head_from_skid;

  assign out_valid = (state_q != SK_EMPTY);
  assign out_data  = head_data;
  assign out_ctrl  = out_valid ? head_ctrl : '0;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~state_q[1];
    end else begin : g_single
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready & ~flush;
  assign stall_inc = out_valid & ~out_ready & ~flush;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SK_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // With SKID=0 in_ready is low whenever FULL without consume, so BOTH is never entered.
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_d = SK_EMPTY;
    end else begin
      case (state_q)
        SK_EMPTY: begin
          if (accept) begin
            state_d   = SK_FULL;
            load_head = 1'b1;
          end
        end
        SK_FULL: begin
          if (accept && consume) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = SK_BOTH;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = SK_EMPTY;
          end
        end
        SK_BOTH: begin
          if (consume) begin
            state_d        = SK_FULL;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = SK_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_head) begin
        head_data <= in_data;
        head_ctrl <= in_ctrl;
      end else if (head_from_skid) begin
        head_data <= skid_data;
        head_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (stall_inc),
    .clr  (stall_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (single, skid, 4-bit counter) share stimulus; queue model plus directed vectors.
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  logic        clock, reset;
  logic        in_valid, out_ready, flush, stall_clr;
  logic [31:0] in_data;
  logic [2:0]  in_ctrl;

  logic        in_ready0, out_valid0, in_ready1, out_valid1, in_ready2, out_valid2;
  logic [31:0] out_data0, out_data1, out_data2;
  logic [2:0]  out_ctrl0, out_ctrl1, out_ctrl2;
  logic [15:0] stall_cnt0, stall_cnt1;
  logic [3:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: q0 serves both single-entry instances, q1 the skid instance.
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic [31:0] ld0, ld1;
  int          c0, c1, c2;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        orr;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        er;
  } vec_t;
  vec_t tbl[6];

  pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .SKID(0), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .flush(flush), .stall_cnt(stall_cnt0),
    .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .SKID(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .flush(flush), .stall_cnt(stall_cnt1),
    .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .SKID(0), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_ctrl(out_ctrl2), .flush(flush), .stall_cnt(stall_cnt2),
    .stall_clr(stall_clr)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ld0 = '0;
    ld1 = '0;
    c0 = 0;
    c1 = 0;
    c2 = 0;
  endtask

  task automatic model_edge();
    bit v0, v1, r0, r1;
    v0 = (q0.size() != 0);
    v1 = (q1.size() != 0);
    r0 = out_ready || !v0;
    r1 = (q1.size() < 2);
    if (stall_clr) begin
      c0 = 0; c1 = 0; c2 = 0;
    end else if (!flush && !out_ready) begin
      if (v0) begin
        if (c0 < 65535) c0++;
        if (c2 < 15) c2++;
      end
      if (v1 && c1 < 65535) c1++;
    end
    if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (v0 && out_ready) void'(q0.pop_front());
      if (v1 && out_ready) void'(q1.pop_front());
      if (in_valid && r0) q0.push_back({in_ctrl, in_data});
      if (in_valid && r1) q1.push_back({in_ctrl, in_data});
    end
    if (q0.size() != 0) ld0 = q0[0][31:0];
    if (q1.size() != 0) ld1 = q1[0][31:0];
  endtask

  task automatic check_state(input string tag);
    logic [34:0] h0, h1;
    h0 = (q0.size() != 0) ? q0[0] : {3'b000, ld0};
    h1 = (q1.size() != 0) ? q1[0] : {3'b000, ld1};
    chk({tag, ":vld0"}, 32'(out_valid0), 32'(q0.size() != 0));
    chk({tag, ":dat0"}, out_data0, h0[31:0]);
    chk({tag, ":ctl0"}, 32'(out_ctrl0), 32'(h0[34:32]));
    chk({tag, ":cnt0"}, 32'(stall_cnt0), 32'(c0));
    chk({tag, ":vld2"}, 32'(out_valid2), 32'(q0.size() != 0));
    chk({tag, ":dat2"}, out_data2, h0[31:0]);
    chk({tag, ":ctl2"}, 32'(out_ctrl2), 32'(h0[34:32]));
    chk({tag, ":cnt2"}, 32'(stall_cnt2), 32'(c2));
    chk({tag, ":vld1"}, 32'(out_valid1), 32'(q1.size() != 0));
    chk({tag, ":dat1"}, out_data1, h1[31:0]);
    chk({tag, ":ctl1"}, 32'(out_ctrl1), 32'(h1[34:32]));
    chk({tag, ":cnt1"}, 32'(stall_cnt1), 32'(c1));
    chk({tag, ":rdy1"}, 32'(in_ready1), 32'(q1.size() < 2));
  endtask

  // Inputs are set by the caller beforehand and stay stable across the falling edge.
  task automatic step(input string tag);
    #1;
    chk({tag, ":irdy0"}, 32'(in_ready0), 32'(out_ready || q0.size() == 0));
    chk({tag, ":irdy2"}, 32'(in_ready2), 32'(out_ready || q0.size() == 0));
    model_edge();
    @(negedge clock);
    #1;
    check_state(tag);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_clear();
    #1;
    check_state("rst");
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{iv: 1'b1, d: 32'h11, orr: 1'b0, ev: 1'b1, ed: 32'h11, ec: 3'b101, er: 1'b1};
    tbl[1] = '{iv: 1'b1, d: 32'h22, orr: 1'b0, ev: 1'b1, ed: 32'h11, ec: 3'b101, er: 1'b0};
    tbl[2] = '{iv: 1'b1, d: 32'h33, orr: 1'b0, ev: 1'b1, ed: 32'h11, ec: 3'b101, er: 1'b0};
    tbl[3] = '{iv: 1'b1, d: 32'h33, orr: 1'b1, ev: 1'b1, ed: 32'h22, ec: 3'b101, er: 1'b1};
    tbl[4] = '{iv: 1'b1, d: 32'h33, orr: 1'b1, ev: 1'b1, ed: 32'h33, ec: 3'b101, er: 1'b1};
    tbl[5] = '{iv: 1'b0, d: 32'h00, orr: 1'b1, ev: 1'b0, ed: 32'h33, ec: 3'b000, er: 1'b1};

    idle_inputs();
    reset = 1'b1;
    model_clear();
    #3;
    check_state("init");
    chk("init:irdy1", 32'(in_ready1), 32'd1);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Single accept, 1-edge latency
    in_valid  = 1'b1;
    in_data   = 32'h0000_00A5;
    in_ctrl   = '0;
    in_ctrl[CTRL_REGWR]    = 1'b1;
    in_ctrl[CTRL_MEMTOREG] = 1'b1;
    out_ready = 1'b1;
    step("t1");
    chk("t1:valid", 32'(out_valid0), 32'd1);
    chk("t1:data", out_data0, 32'hA5);
    chk("t1:ctrl", 32'(out_ctrl0), 32'b011);
    in_valid = 1'b0;
    step("t1b");

    // Skid fill, blocked offer, drain in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      in_ctrl   = 3'b101;
      out_ready = tbl[i].orr;
      step("tbl");
      chk($sformatf("tbl%0d:vld", i), 32'(out_valid1), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d:dat", i), out_data1, tbl[i].ed);
      chk($sformatf("tbl%0d:ctl", i), 32'(out_ctrl1), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d:rdy", i), 32'(in_ready1), 32'(tbl[i].er));
    end

    // Single-entry stall for 5 edges, then flush, then clear
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'h5A;
    in_ctrl  = 3'b010;
    step("t3load");
    in_data = 32'h77;
    repeat (5) step("t3");
    chk("t3:head", out_data0, 32'h5A);
    chk("t3:irdy", 32'(in_ready0), 32'd0);
    chk("t3:cnt", 32'(stall_cnt0), 32'd5);
    flush     = 1'b1;
    in_data   = 32'h99;
    out_ready = 1'b1;
    step("t4");
    chk("t4:vld", 32'(out_valid0), 32'd0);
    chk("t4:ctl", 32'(out_ctrl0), 32'd0);
    chk("t4:cnt", 32'(stall_cnt0), 32'd5);
    flush    = 1'b0;
    in_valid = 1'b0;
    step("t4b");
    chk("t4:discard", 32'(out_valid0), 32'd0);
    stall_clr = 1'b1;
    step("t3clr");
    chk("t3:clr", 32'(stall_cnt0), 32'd0);
    stall_clr = 1'b0;

    // 4-bit counter saturation
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'hC3;
    step("t5load");
    in_valid = 1'b0;
    repeat (20) step("t5");
    chk("t5:sat", 32'(stall_cnt2), 32'd15);
    step("t5b");
    chk("t5:hold", 32'(stall_cnt2), 32'd15);
    chk("t5:wide", 32'(stall_cnt0), 32'd21);

    // Reset between edges while skid holds two entries
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'h11;
    in_ctrl  = 3'b111;
    step("t6a");
    in_data = 32'h22;
    step("t6b");
    chk("t6:both", 32'(in_ready1), 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6:vld", 32'(out_valid1), 32'd0);
    chk("t6:ctl", 32'(out_ctrl1), 32'd0);
    chk("t6:cnt", 32'(stall_cnt1), 32'd0);
    chk("t6:dat", out_data1, 32'd0);
    chk("t6:irdy", 32'(in_ready1), 32'd1);
    model_clear();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    out_ready = 1'b1;
    step("t6c");
    chk("t6:first", 32'(out_valid1), 32'd1);
    chk("t6:fdat", out_data1, 32'h44);

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = 3'($urandom);
      out_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
